// File: rtl/aquila_dram_read_arbiter.sv
// aquila_dram_read_arbiter
// Shares one AXI4 read port of the DRAM slave between the instruction-cache
// and data-cache read masters. Round-robin arbitration, one burst in flight,
// beat counting with a sticky burst-length error flag. Write channels bypass.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ICACHE_AXI_* / DCACHE_AXI_* AR and R channels of the two cache masters
//                              (R data/resp/last broadcast to both)
//   M_AXI_*                    AR and R channels towards memory; arid 0=I, 1=D
//   grant                      one-hot owner (bit0 ICACHE, bit1 DCACHE), 00 idle
//   len_err                    sticky burst-length mismatch
module aquila_dram_read_arbiter #(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // ICACHE read master
  input  logic                    ICACHE_AXI_arvalid,
  output logic                    ICACHE_AXI_arready,
  input  logic [C_ADDR_WIDTH-1:0] ICACHE_AXI_araddr,
  input  logic [7:0]              ICACHE_AXI_arlen,
  output logic                    ICACHE_AXI_rvalid,
  input  logic                    ICACHE_AXI_rready,
  output logic [C_DATA_WIDTH-1:0] ICACHE_AXI_rdata,
  output logic [1:0]              ICACHE_AXI_rresp,
  output logic                    ICACHE_AXI_rlast,
  // DCACHE read master
  input  logic                    DCACHE_AXI_arvalid,
  output logic                    DCACHE_AXI_arready,
  input  logic [C_ADDR_WIDTH-1:0] DCACHE_AXI_araddr,
  input  logic [7:0]              DCACHE_AXI_arlen,
  output logic                    DCACHE_AXI_rvalid,
  input  logic                    DCACHE_AXI_rready,
  output logic [C_DATA_WIDTH-1:0] DCACHE_AXI_rdata,
  output logic [1:0]              DCACHE_AXI_rresp,
  output logic                    DCACHE_AXI_rlast,
  // Memory side
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  output logic [C_ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic                    M_AXI_arid,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready,
  input  logic [C_DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  // Status
  output logic [1:0]              grant,
  output logic                    len_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state;
  logic [7:0] beat_cnt;
  logic       rr_d_first;  // 1: DCACHE wins the next tie

  logic in_idle, in_data;
  logic sel_i, sel_d;
  logic beat_hs, cnt_hit, burst_end;

  always_comb begin
    in_idle = (state == StIdle);
    in_data = (state == StData);

    sel_i = ICACHE_AXI_arvalid & (~DCACHE_AXI_arvalid | ~rr_d_first);
    sel_d = DCACHE_AXI_arvalid & (~ICACHE_AXI_arvalid | rr_d_first);

    ICACHE_AXI_arready = in_idle & sel_i;
    DCACHE_AXI_arready = in_idle & sel_d;

    // M_AXI_arid doubles as the owner index while a burst is in flight
    ICACHE_AXI_rvalid = in_data & ~M_AXI_arid & M_AXI_rvalid;
    DCACHE_AXI_rvalid = in_data & M_AXI_arid & M_AXI_rvalid;
    M_AXI_rready      = in_data & (M_AXI_arid ? DCACHE_AXI_rready : ICACHE_AXI_rready);

    beat_hs   = M_AXI_rvalid & M_AXI_rready;
    cnt_hit   = (beat_cnt == M_AXI_arlen);
    burst_end = beat_hs & (M_AXI_rlast | cnt_hit);
  end

  assign ICACHE_AXI_rdata = M_AXI_rdata;
  assign ICACHE_AXI_rresp = M_AXI_rresp;
  assign ICACHE_AXI_rlast = M_AXI_rlast;
  assign DCACHE_AXI_rdata = M_AXI_rdata;
  assign DCACHE_AXI_rresp = M_AXI_rresp;
  assign DCACHE_AXI_rlast = M_AXI_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      M_AXI_arvalid <= 1'b0;
      M_AXI_araddr  <= '0;
      M_AXI_arlen   <= '0;
      M_AXI_arid    <= 1'b0;
      grant         <= 2'b00;
      len_err       <= 1'b0;
      beat_cnt      <= '0;
      rr_d_first    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (sel_i | sel_d) begin
            M_AXI_araddr  <= sel_i ? ICACHE_AXI_araddr : DCACHE_AXI_araddr;
            M_AXI_arlen   <= sel_i ? ICACHE_AXI_arlen : DCACHE_AXI_arlen;
            M_AXI_arid    <= sel_d;
            grant         <= sel_i ? 2'b01 : 2'b10;
            M_AXI_arvalid <= 1'b1;
            state         <= StAddr;
          end
        end
        StAddr: begin
          if (M_AXI_arready) begin
            M_AXI_arvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= StData;
          end
        end
        StData: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // rlast and the beat count must agree on which beat is last
            if (M_AXI_rlast != cnt_hit) len_err <= 1'b1;
            if (burst_end) begin
              state      <= StIdle;
              grant      <= 2'b00;
              rr_d_first <= ~M_AXI_arid;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aquila_dram_read_arbiter.sv
// Self-checking bench for aquila_dram_read_arbiter: a behavioural memory slave,
// a scoreboard of expected AR requests and R beats, and one task per scenario.
module tb_aquila_dram_read_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic [1:0]  i_rresp;
  logic        d_arvalid, d_arready, d_rvalid, d_rready, d_rlast;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [1:0]  d_rresp;
  logic        m_arvalid, m_arready, m_arid, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [1:0]  m_rresp;
  logic [1:0]  grant;
  logic        len_err;

  aquila_dram_read_arbiter #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_AXI_arvalid(i_arvalid), .ICACHE_AXI_arready(i_arready),
    .ICACHE_AXI_araddr(i_araddr), .ICACHE_AXI_arlen(i_arlen),
    .ICACHE_AXI_rvalid(i_rvalid), .ICACHE_AXI_rready(i_rready),
    .ICACHE_AXI_rdata(i_rdata), .ICACHE_AXI_rresp(i_rresp), .ICACHE_AXI_rlast(i_rlast),
    .DCACHE_AXI_arvalid(d_arvalid), .DCACHE_AXI_arready(d_arready),
    .DCACHE_AXI_araddr(d_araddr), .DCACHE_AXI_arlen(d_arlen),
    .DCACHE_AXI_rvalid(d_rvalid), .DCACHE_AXI_rready(d_rready),
    .DCACHE_AXI_rdata(d_rdata), .DCACHE_AXI_rresp(d_rresp), .DCACHE_AXI_rlast(d_rlast),
    .M_AXI_arvalid(m_arvalid), .M_AXI_arready(m_arready),
    .M_AXI_araddr(m_araddr), .M_AXI_arlen(m_arlen), .M_AXI_arid(m_arid),
    .M_AXI_rvalid(m_rvalid), .M_AXI_rready(m_rready),
    .M_AXI_rdata(m_rdata), .M_AXI_rresp(m_rresp), .M_AXI_rlast(m_rlast),
    .grant(grant), .len_err(len_err)
  );

  typedef struct packed {logic id; logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic id; logic [31:0] addr; logic [7:0] len;} ar_t;

  beat_t r_q[$];
  ar_t   ar_q[$];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int last_r_cyc = -100;
  int hs_cnt = 0;
  bit in_data = 0, chk_stable = 0, chk_rready = 0;
  logic [31:0] stab_addr;
  logic [7:0]  stab_len;

  // Memory model configuration
  int cfg_ar_delay = 0;
  bit cfg_gaps = 0;
  int cfg_early = -1;

  // Handshakes seen at the last negedge (i.e. taken at the coming posedge)
  bit f_ar_hs = 0, f_r_hs = 0;
  logic [31:0] hs_addr;
  logic [7:0]  hs_len;

  bit m_busy = 0;
  int m_beat = 0, m_len = 0, ar_wait = 0;
  logic [31:0] m_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard
  logic        mon_v, mon_l, mon_p;
  logic [31:0] mon_d;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      f_ar_hs = 0;
      f_r_hs  = 0;
    end else begin
      if (chk_rready && in_data) begin
        vectors++;
        if (m_rready !== d_rready) begin
          errs++;
          $display("FAIL rready_track: M_AXI_rready=%b D_rready=%b", m_rready, d_rready);
        end
      end
      if (chk_stable && m_arvalid) begin
        vectors++;
        if ({m_araddr, m_arlen} !== {stab_addr, stab_len}) begin
          errs++;
          $display("FAIL ar_stable: got %h/%0d want %h/%0d", m_araddr, m_arlen, stab_addr,
                   stab_len);
        end
      end
      f_ar_hs = m_arvalid && m_arready;
      f_r_hs  = m_rvalid && m_rready;
      if (f_ar_hs) begin
        hs_addr = m_araddr;
        hs_len  = m_arlen;
        in_data = 1;
        vectors++;
        if (ar_q.size() == 0) begin
          errs++;
          $display("FAIL ar_unexpected: got id=%0d addr=%h len=%0d want none", m_arid,
                   m_araddr, m_arlen);
        end else begin
          ar_t e;
          e = ar_q.pop_front();
          if ({m_arid, m_araddr, m_arlen} !== {e.id, e.addr, e.len}) begin
            errs++;
            $display("FAIL ar_fields: got id=%0d addr=%h len=%0d want id=%0d addr=%h len=%0d",
                     m_arid, m_araddr, m_arlen, e.id, e.addr, e.len);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        mon_p = (p == 1);
        mon_v = mon_p ? (d_rvalid && d_rready) : (i_rvalid && i_rready);
        mon_d = mon_p ? d_rdata : i_rdata;
        mon_l = mon_p ? d_rlast : i_rlast;
        if (mon_v) begin
          hs_cnt++;
          vectors++;
          if (r_q.size() == 0) begin
            errs++;
            $display("FAIL r_unexpected: got port=%0d data=%h last=%b want none", p, mon_d,
                     mon_l);
          end else begin
            beat_t e;
            e = r_q.pop_front();
            if ({mon_p, mon_d, mon_l} !== {e.id, e.data, e.last}) begin
              errs++;
              $display("FAIL r_beat: got port=%0d data=%h last=%b want port=%0d data=%h last=%b",
                       p, mon_d, mon_l, e.id, e.data, e.last);
            end
          end
          if (mon_l) begin
            last_r_cyc = cyc;
            in_data = 0;
          end
        end
      end
    end
  end

  // Memory slave model
  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_busy = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; ar_wait = 0;
      end else begin
        if (!m_busy) begin
          if (f_ar_hs) begin
            m_busy = 1; m_addr = hs_addr; m_len = int'(hs_len); m_beat = 0;
            m_arready = 0; ar_wait = 0; m_rvalid = 0;
          end else begin
            m_arready = m_arvalid && (ar_wait >= cfg_ar_delay);
            if (m_arvalid) ar_wait++;
          end
        end else if (f_r_hs) begin
          if (m_rlast) m_busy = 0;
          m_beat++;
          m_rvalid = 0;
        end
        if (m_busy && !m_rvalid) m_rvalid = cfg_gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_rdata = m_addr + 32'(m_beat);
        m_rlast = m_busy && ((m_beat == m_len) || (m_beat == cfg_early));
      end
    end
  end

  task automatic push_burst(input logic id, input logic [31:0] addr, input int len,
                            input int early);
    ar_t a;
    beat_t b;
    a.id = id; a.addr = addr; a.len = 8'(len);
    ar_q.push_back(a);
    for (int k = 0; k <= len; k++) begin
      b.id = id; b.data = addr + 32'(k); b.last = (k == len) || (k == early);
      r_q.push_back(b);
      if (b.last) break;
    end
  endtask

  task automatic issue(input logic id, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clk); #1;
    if (id) begin d_arvalid = 1; d_araddr = addr; d_arlen = len; end
    else    begin i_arvalid = 1; i_araddr = addr; i_arlen = len; end
    @(negedge clk);
    vectors++;
    if ({i_arready, d_arready, m_arvalid} !== (id ? 3'b010 : 3'b100)) begin
      errs++;
      $display("FAIL issue_arready: got i/d/m=%b%b%b want %b", i_arready, d_arready,
               m_arvalid, (id ? 3'b010 : 3'b100));
    end
    @(posedge clk); #1;
    i_arvalid = 0; d_arvalid = 0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (toggle) d_rready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (r_q.size() == 0 && ar_q.size() == 0 && grant == 2'b00) done = 1;
    end
    d_rready = 1;
    vectors++;
    if (!done) begin
      errs++;
      $display("FAIL burst_timeout: got r_left=%0d ar_left=%0d grant=%b want 0/0/00",
               r_q.size(), ar_q.size(), grant);
    end
  endtask

  task automatic test_reset;
    i_arvalid = 0; d_arvalid = 0; i_rready = 1; d_rready = 1;
    i_araddr = '0; d_araddr = '0; i_arlen = '0; d_arlen = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({grant, m_arvalid, len_err, i_arready, d_arready, m_rready} !== 7'b0) begin
      errs++;
      $display("FAIL reset_state: got grant=%b arv=%b lerr=%b ar=%b%b rr=%b want all 0",
               grant, m_arvalid, len_err, i_arready, d_arready, m_rready);
    end
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  // Both masters request together; 'first' is the expected winner
  task automatic test_arb(input logic first, input logic [31:0] a_i, input int l_i,
                          input logic [31:0] a_d, input int l_d);
    bit got = 0;
    if (first) begin push_burst(1, a_d, l_d, -1); push_burst(0, a_i, l_i, -1); end
    else       begin push_burst(0, a_i, l_i, -1); push_burst(1, a_d, l_d, -1); end
    @(posedge clk); #1;
    i_arvalid = 1; i_araddr = a_i; i_arlen = 8'(l_i);
    d_arvalid = 1; d_araddr = a_d; d_arlen = 8'(l_d);
    @(negedge clk);
    vectors++;
    if ({i_arready, d_arready} !== (first ? 2'b01 : 2'b10)) begin
      errs++;
      $display("FAIL tie_winner: got i/d arready=%b%b want %b", i_arready, d_arready,
               (first ? 2'b01 : 2'b10));
    end
    @(posedge clk); #1;
    if (first) d_arvalid = 0; else i_arvalid = 0;
    @(negedge clk);
    vectors++;
    if ({m_arvalid, grant} !== {1'b1, (first ? 2'b10 : 2'b01)}) begin
      errs++;
      $display("FAIL tie_latency: got arvalid=%b grant=%b want 1 %b", m_arvalid, grant,
               (first ? 2'b10 : 2'b01));
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (first ? i_arready : d_arready) begin got = 1; break; end
    end
    vectors++;
    if (!got || cyc != last_r_cyc + 1) begin
      errs++;
      $display("FAIL tie_second: got granted=%0d at cyc %0d want cyc %0d", got, cyc,
               last_r_cyc + 1);
    end
    @(posedge clk); #1;
    i_arvalid = 0; d_arvalid = 0;
    wait_done(300, 0);
  endtask

  task automatic test_icache_only;
    int hs0 = hs_cnt;
    push_burst(0, 32'h1000, 7, -1);
    issue(0, 32'h1000, 8'd7);
    @(negedge clk);
    vectors++;
    if ({m_arvalid, m_arid, grant} !== 4'b1001) begin
      errs++;
      $display("FAIL icache_ar_next: got arvalid=%b arid=%b grant=%b want 1 0 01",
               m_arvalid, m_arid, grant);
    end
    wait_done(200, 0);
    vectors++;
    if (hs_cnt - hs0 != 8 || grant !== 2'b00 || len_err !== 1'b0) begin
      errs++;
      $display("FAIL icache_burst: got beats=%0d grant=%b lerr=%b want 8 00 0",
               hs_cnt - hs0, grant, len_err);
    end
  endtask

  task automatic test_midburst;
    bit got = 0;
    cfg_ar_delay = 2;
    push_burst(1, 32'h4000, 3, -1);
    push_burst(0, 32'h4100, 2, -1);
    issue(1, 32'h4000, 8'd3);
    @(posedge clk); #1;
    i_arvalid = 1; i_araddr = 32'h4100; i_arlen = 8'd2;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i_arready) begin got = 1; break; end
    end
    vectors++;
    if (!got || cyc != last_r_cyc + 1) begin
      errs++;
      $display("FAIL midburst_hold: got arready=%0d at cyc %0d want cyc %0d", got, cyc,
               last_r_cyc + 1);
    end
    @(posedge clk); #1;
    i_arvalid = 0;
    wait_done(200, 0);
    cfg_ar_delay = 0;
  endtask

  task automatic test_stalls;
    int hs0 = hs_cnt;
    cfg_ar_delay = 5; cfg_gaps = 1;
    stab_addr = 32'h5000; stab_len = 8'd3;
    chk_stable = 1; chk_rready = 1;
    push_burst(1, 32'h5000, 3, -1);
    issue(1, 32'h5000, 8'd3);
    wait_done(300, 1);
    chk_stable = 0; chk_rready = 0;
    vectors++;
    if (hs_cnt - hs0 != 4) begin
      errs++;
      $display("FAIL stall_beats: got %0d want 4", hs_cnt - hs0);
    end
    cfg_ar_delay = 0; cfg_gaps = 0;
  endtask

  task automatic test_early_last;
    cfg_early = 2;
    push_burst(0, 32'h6000, 3, 2);
    issue(0, 32'h6000, 8'd3);
    wait_done(200, 0);
    vectors++;
    if (len_err !== 1'b1) begin
      errs++;
      $display("FAIL len_err_set: got %b want 1", len_err);
    end
    cfg_early = -1;
    push_burst(1, 32'h6100, 0, -1);
    issue(1, 32'h6100, 8'd0);
    wait_done(200, 0);
    vectors++;
    if (len_err !== 1'b1) begin
      errs++;
      $display("FAIL len_err_sticky: got %b want 1", len_err);
    end
  endtask

  task automatic test_reset_mid;
    bit got = 0;
    push_burst(0, 32'h7000, 3, -1);
    issue(0, 32'h7000, 8'd3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (r_q.size() == 3) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin
      errs++;
      $display("FAIL reset_mid_beat0: got r_left=%0d want 3", r_q.size());
    end
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    vectors++;
    if ({m_arvalid, grant, len_err, i_rvalid, d_rvalid, m_rready} !== 7'b0) begin
      errs++;
      $display("FAIL reset_mid_async: got arv=%b grant=%b lerr=%b rv=%b%b rr=%b want all 0",
               m_arvalid, grant, len_err, i_rvalid, d_rvalid, m_rready);
    end
    r_q.delete(); ar_q.delete(); in_data = 0;
    @(posedge clk); #3;
    rst_n = 1;
    push_burst(0, 32'h7100, 1, -1);
    issue(0, 32'h7100, 8'd1);
    wait_done(200, 0);
    vectors++;
    if (len_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_after: got lerr=%b want 0", len_err);
    end
  endtask

  task automatic test_long;
    push_burst(1, 32'h8000, 255, -1);
    issue(1, 32'h8000, 8'd255);
    wait_done(600, 0);
    vectors++;
    if (len_err !== 1'b0) begin
      errs++;
      $display("FAIL long_burst_lerr: got %b want 0", len_err);
    end
  endtask

  initial begin
    test_reset();
    test_arb(0, 32'h2000, 1, 32'h3000, 2);  // from reset: ICACHE wins
    test_arb(0, 32'h2100, 2, 32'h3100, 1);  // after DCACHE served: ICACHE wins
    test_icache_only();
    test_arb(1, 32'h2200, 0, 32'h3200, 3);  // after ICACHE served: DCACHE wins
    test_midburst();
    test_stalls();
    test_early_last();
    test_reset_mid();
    test_long();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
